// File: rtl/gfx_pattern_gen.sv
// gfx_pattern_gen: framebuffer fill engine. Walks every visible pixel of an
// H_VISIBLE x V_VISIBLE frame in raster order and emits (addr, color) beats
// on a valid/ready stream. Single-shot or continuous frames, frame counter.
// Optional feature macro: GFX_PATTERN_ANIMATE_EN scrolls the pattern one
// pixel to the left per completed frame (pattern x = (x + offset) mod H).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start, no beats offered
// ST_RUN   | emitting beats; returns to ST_IDLE after the last frame ends
module gfx_pattern_gen #(
    parameter int H_VISIBLE      = 640,
    parameter int V_VISIBLE      = 480,
    parameter int PIXEL_BITS     = 12,
    parameter int ADDR_WIDTH     = 20,
    parameter int BAR_SHIFT      = 4,
    parameter int FRAME_CNT_BITS = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic                      continuous,
    input  logic                      stop,
    input  logic [2:0]                mode,
    input  logic [PIXEL_BITS-1:0]     fg_color,
    input  logic [PIXEL_BITS-1:0]     bg_color,
    output logic                      busy,
    output logic                      done,
    output logic [FRAME_CNT_BITS-1:0] frame_count,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic [ADDR_WIDTH-1:0]     pix_addr,
    output logic [PIXEL_BITS-1:0]     pix_color
);
    localparam int COLOR_BITS = PIXEL_BITS / 3;
    localparam int XW  = $clog2(H_VISIBLE);
    localparam int YW  = $clog2(V_VISIBLE);
    localparam int XW1 = XW + 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_VISIBLE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_VISIBLE - 1);

    typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                state, state_next;
    logic [XW-1:0]         x, x_n, xe_n;
    logic [YW-1:0]         y, y_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [2:0]            cfg_mode, mode_n;
    logic [PIXEL_BITS-1:0] cfg_fg, cfg_bg, fg_n, bg_n, color_n;
    logic                  cfg_cont, cont_n, stop_pending, stop_n;
    logic [FRAME_CNT_BITS-1:0] fcnt_n;
    logic                  done_n;
    logic                  beat, frame_end, frame_again;

    // A beat is accepted whenever RUN offers one and downstream takes it.
    assign beat        = (state == ST_RUN) && pix_ready;
    assign frame_end   = beat && (x == X_LAST) && (y == Y_LAST);
    // A stop arriving on the very last beat still counts as pending.
    assign frame_again = frame_end && cfg_cont && !stop_pending && !stop;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (frame_end && !frame_again) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the stream is valid for the whole of RUN (no bubbles).
    always_comb begin
        busy      = (state == ST_RUN);
        pix_valid = (state == ST_RUN);
    end

    // Next coordinate, address and configuration.
    always_comb begin
        x_n    = x;
        y_n    = y;
        addr_n = pix_addr;
        mode_n = cfg_mode;
        fg_n   = cfg_fg;
        bg_n   = cfg_bg;
        cont_n = cfg_cont;
        stop_n = stop_pending;
        fcnt_n = frame_count;
        done_n = 1'b0;
        if (state == ST_IDLE) begin
            if (start) begin
                x_n    = '0;
                y_n    = '0;
                addr_n = '0;
                mode_n = mode;
                fg_n   = fg_color;
                bg_n   = bg_color;
                cont_n = continuous;
                stop_n = 1'b0;
            end
        end else begin
            if (stop) stop_n = 1'b1;
            if (frame_end) begin
                x_n    = '0;
                y_n    = '0;
                addr_n = '0;
                fcnt_n = frame_count + FRAME_CNT_BITS'(1);
                if (frame_again) begin
                    mode_n = mode;
                    fg_n   = fg_color;
                    bg_n   = bg_color;
                end else begin
                    done_n = 1'b1;
                end
            end else if (beat) begin
                addr_n = pix_addr + ADDR_WIDTH'(1);
                if (x == X_LAST) begin
                    x_n = '0;
                    y_n = y + YW'(1);
                end else begin
                    x_n = x + XW'(1);
                end
            end
        end
    end

`ifdef GFX_PATTERN_ANIMATE_EN
    logic [XW-1:0]  offset, offset_n;
    logic [XW1-1:0] xe_sum;

    // Horizontal scroll offset advances once per completed frame.
    always_comb begin
        offset_n = offset;
        if (frame_end) offset_n = (offset == X_LAST) ? '0 : offset + XW'(1);
        xe_sum = {1'b0, x_n} + {1'b0, offset_n};
        if (xe_sum >= XW1'(H_VISIBLE)) xe_n = XW'(xe_sum - XW1'(H_VISIBLE));
        else                           xe_n = xe_sum[XW-1:0];
    end

    // Offset register; survives frames and jobs, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) offset <= '0;
        else          offset <= offset_n;
    end
`else
    // Without animation the pattern x is the raster x.
    always_comb xe_n = x_n;
`endif

    // Color of the pixel that will be on the bus next cycle.
    always_comb begin
        logic [XW-1:0] xs;
        logic [YW-1:0] ys;
        xs = xe_n >> BAR_SHIFT;
        ys = y_n >> BAR_SHIFT;
        case (mode_n)
            3'd0:    color_n = fg_n;
            3'd1:    color_n = ys[0] ? fg_n : bg_n;
            3'd2:    color_n = xs[0] ? fg_n : bg_n;
            3'd3:    color_n = (xs[0] ^ ys[0]) ? fg_n : bg_n;
            3'd4:    color_n = {COLOR_BITS'(xe_n), COLOR_BITS'(y_n),
                                COLOR_BITS'(xe_n) ^ COLOR_BITS'(y_n)};
            default: color_n = bg_n;
        endcase
    end

    // Datapath registers; everything holds while a beat is stalled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x            <= '0;
            y            <= '0;
            pix_addr     <= '0;
            pix_color    <= '0;
            cfg_mode     <= '0;
            cfg_fg       <= '0;
            cfg_bg       <= '0;
            cfg_cont     <= 1'b0;
            stop_pending <= 1'b0;
            frame_count  <= '0;
            done         <= 1'b0;
        end else begin
            x            <= x_n;
            y            <= y_n;
            pix_addr     <= addr_n;
            pix_color    <= color_n;
            cfg_mode     <= mode_n;
            cfg_fg       <= fg_n;
            cfg_bg       <= bg_n;
            cfg_cont     <= cont_n;
            stop_pending <= stop_n;
            frame_count  <= fcnt_n;
            done         <= done_n;
        end
    end
endmodule

// File: tb/tb_gfx_pattern_gen.sv
// Scoreboard bench for gfx_pattern_gen on an 8x4 frame, 12-bit pixels,
// 2-pixel bars and a 3-bit frame counter (so counter wrap is reachable).
module tb_gfx_pattern_gen;
    localparam int H = 8;
    localparam int V = 4;
    localparam int BAR = 2;

    logic        clk, reset_n, start, continuous, stop, pix_ready;
    logic [2:0]  mode;
    logic [11:0] fg_color, bg_color, pix_color;
    logic        busy, done, pix_valid;
    logic [2:0]  frame_count;
    logic [4:0]  pix_addr;

    gfx_pattern_gen #(
        .H_VISIBLE(H), .V_VISIBLE(V), .PIXEL_BITS(12), .ADDR_WIDTH(5),
        .BAR_SHIFT(1), .FRAME_CNT_BITS(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .stop(stop), .mode(mode), .fg_color(fg_color), .bg_color(bg_color),
        .busy(busy), .done(done), .frame_count(frame_count),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_addr(pix_addr),
        .pix_color(pix_color)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [11:0] color;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    int          exp_fc = 0;
    int          off = 0;
    bit          rand_ready = 0;
    logic [11:0] obs[0:4095];

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got no summary, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Reference color from the pattern rules, using plain integer arithmetic.
    function automatic logic [11:0] model_color(input logic [2:0] m, input logic [11:0] fg,
                                                input logic [11:0] bg, input int xx, input int yy,
                                                input int o);
        int xe;
        logic [3:0] r, g, b;
        xe = (xx + o) % H;
        r = 4'(xe % 16);
        g = 4'(yy % 16);
        b = 4'((xe ^ yy) % 16);
        case (m)
            3'd0: return fg;
            3'd1: return ((yy / BAR) % 2 == 1) ? fg : bg;
            3'd2: return ((xe / BAR) % 2 == 1) ? fg : bg;
            3'd3: return (((xe / BAR) + (yy / BAR)) % 2 == 1) ? fg : bg;
            3'd4: return {r, g, b};
            default: return bg;
        endcase
    endfunction

    task automatic push_frame(input logic [2:0] m, input logic [11:0] fg, input logic [11:0] bg,
                              input bit last);
        exp_t e;
        for (int yy = 0; yy < V; yy++) begin
            for (int xx = 0; xx < H; xx++) begin
                e.addr  = 5'(yy * H + xx);
                e.color = model_color(m, fg, bg, xx, yy, off);
                e.last  = last && (yy == V - 1) && (xx == H - 1);
                exp_q.push_back(e);
            end
        end
`ifdef GFX_PATTERN_ANIMATE_EN
        off = (off + 1) % H;
`endif
        exp_fc++;
    endtask

    // Downstream ready: steady 1 or a coin flip each cycle.
    initial begin
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: pops the scoreboard on every accepted beat, checks stalls and done.
    initial begin
        exp_t e;
        bit          prev_stall = 0;
        bit          exp_done_next = 0;
        logic [4:0]  prev_addr = '0;
        logic [11:0] prev_color = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_stall = 0;
                exp_done_next = 0;
            end else begin
                if (done || exp_done_next) begin
                    check("done_pulse", done, exp_done_next);
                    if (exp_done_next) check("busy_at_done", busy, 0);
                end
                exp_done_next = 0;
                if (prev_stall) begin
                    check("stall_valid", pix_valid, 1);
                    check("stall_addr", pix_addr, prev_addr);
                    check("stall_color", pix_color, prev_color);
                end
                if (pix_valid && pix_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr %0h, required no beat", pix_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", pix_addr, e.addr);
                        check("beat_color", pix_color, e.color);
                        if (e.last) exp_done_next = 1;
                    end
                    obs[beats_seen % 4096] = pix_color;
                    beats_seen++;
                end
                prev_stall = pix_valid && !pix_ready;
                prev_addr  = pix_addr;
                prev_color = pix_color;
            end
        end
    end

    task automatic run_job(input logic [2:0] m, input logic [11:0] fg, input logic [11:0] bg,
                           input bit cont, input int stop_at, input int change_at,
                           input logic [2:0] m2, input logic [11:0] fg2, input logic [11:0] bg2,
                           input bit rr, input bit pulse_start, output int base);
        int nfr, n, jb;
        bit stopped, changed, pulsed;
        nfr = cont ? stop_at / (H * V) + 1 : 1;
        for (int f = 0; f < nfr; f++) begin
            if (f > 0 && change_at >= 0 && change_at < f * H * V)
                push_frame(m2, fg2, bg2, f == nfr - 1);
            else
                push_frame(m, fg, bg, f == nfr - 1);
        end
        rand_ready = rr;
        base = beats_seen;
        mode = m;
        fg_color = fg;
        bg_color = bg;
        continuous = cont;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 0;
        stopped = 0;
        changed = 0;
        pulsed = 0;
        while (!done && n < 4000) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("first_valid", pix_valid, 1);
                check("first_addr", pix_addr, 0);
            end
            jb = beats_seen - base;
            if (stop) stop = 0;
            if (start) start = 0;
            if (cont && !stopped && jb >= stop_at) begin
                stop = 1;
                stopped = 1;
            end
            if (!changed && change_at >= 0 && jb >= change_at) begin
                mode = m2;
                fg_color = fg2;
                bg_color = bg2;
                changed = 1;
            end
            if (pulse_start && !pulsed && jb >= 10) begin
                start = 1;
                pulsed = 1;
            end
        end
        start = 0;
        stop = 0;
        check("job_done", done, 1);
        if (!rr) check("job_cycles", n, nfr * H * V + 1);
        check("frame_count", frame_count, exp_fc % 8);
        check("busy_after", busy, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base, n, sa;
        bit c;
        reset_n = 0;
        start = 0;
        continuous = 0;
        stop = 0;
        mode = '0;
        fg_color = '0;
        bg_color = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", pix_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", pix_addr, 0);
        check("rst_color", pix_color, 0);
        check("rst_fcount", frame_count, 0);
        reset_n = 1;
        @(negedge clk);

        // Continuous, vbars; config change in frame 2 must only affect frame 3.
        run_job(3'd2, 12'h0F0, 12'h00F, 1, 70, 40, 3'd0, 12'hABC, 12'h123, 0, 0, base);
        check("cont_f1_a0", obs[base + 0], 12'h00F);
        check("cont_f1_a2", obs[base + 2], 12'h0F0);
`ifdef GFX_PATTERN_ANIMATE_EN
        check("cont_f2_a1", obs[base + 32 + 1], 12'h0F0);
`else
        check("cont_f2_a1", obs[base + 32 + 1], 12'h00F);
`endif
        check("cont_f2_a8", obs[base + 32 + 8], 12'h00F);
        check("cont_f3_a0", obs[base + 64 + 0], 12'hABC);

        // Solid fill, steady ready.
        run_job(3'd0, 12'hF00, 12'h000, 0, 0, -1, 3'd0, 12'h0, 12'h0, 0, 0, base);
        check("solid_a31", obs[base + 31], 12'hF00);

        // Checker with random backpressure.
        run_job(3'd3, 12'hFFF, 12'h000, 0, 0, -1, 3'd0, 12'h0, 12'h0, 1, 0, base);
        check("chk_a0", obs[base + 0], 12'h000);
        check("chk_a2", obs[base + 2], 12'hFFF);
        check("chk_a10", obs[base + 10], 12'hFFF);

        // Gradient with random backpressure.
        run_job(3'd4, 12'h000, 12'h000, 0, 0, -1, 3'd0, 12'h0, 12'h0, 1, 0, base);
`ifdef GFX_PATTERN_ANIMATE_EN
        check("grad_a13", obs[base + 13], 12'h213);
        check("grad_a31", obs[base + 31], 12'h437);
`else
        check("grad_a13", obs[base + 13], 12'h514);
        check("grad_a31", obs[base + 31], 12'h734);
`endif

        // Random jobs with ignored mid-run start, random stops and ready.
        for (int j = 0; j < 4; j++) begin
            c = 1'($urandom_range(0, 1));
            sa = (H * V) * $urandom_range(0, 1) + $urandom_range(3, 28);
            run_job(3'($urandom_range(0, 7)), 12'($urandom), 12'($urandom), c, sa,
                    $urandom_range(5, 25), 3'($urandom_range(0, 7)), 12'($urandom),
                    12'($urandom), 1'($urandom_range(0, 1)), 1, base);
        end

        // Reset in the middle of a frame.
        rand_ready = 0;
        push_frame(3'd1, 12'h0FF, 12'hF0F, 1);
        mode = 3'd1;
        fg_color = 12'h0FF;
        bg_color = 12'hF0F;
        continuous = 0;
        start = 1;
        @(posedge clk);
        #1 start = 0;
        n = 0;
        while (!(pix_valid && pix_addr == 5'd10) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_a10", pix_addr, 10);
        #2 reset_n = 0;
        #1;
        check("mid_rst_valid", pix_valid, 0);
        check("mid_rst_addr", pix_addr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_fcount", frame_count, 0);
        exp_q.delete();
        exp_fc = 0;
        off = 0;
        repeat (2) @(negedge clk);
        check("mid_rst_no_done", done, 0);
        reset_n = 1;
        @(negedge clk);
        check("post_rst_no_done", done, 0);
        run_job(3'd1, 12'h0FF, 12'hF0F, 0, 0, -1, 3'd0, 12'h0, 12'h0, 0, 0, base);
        check("post_rst_a8", obs[base + 8], 12'hF0F);
        check("post_rst_a16", obs[base + 16], 12'h0FF);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gfx_pattern_gen.md
Name: gfx_pattern_gen

Overview:
Parametrised framebuffer fill engine: walks every visible pixel of an H_VISIBLE x V_VISIBLE frame and emits (addr, color) beats on a valid/ready stream.
Sits upstream of the SRAM framebuffer writer and replaces the fixed-pattern draw logic of the gfx demo.
Supports selectable patterns, configurable pixel width and frame geometry, single-shot or continuous frames, and a frame counter.

Parameters:
H_VISIBLE, 640, visible pixels per line (>=2)
V_VISIBLE, 480, visible lines per frame (>=2)
PIXEL_BITS, 12, bits per pixel; must be divisible by 3; COLOR_BITS = PIXEL_BITS/3
ADDR_WIDTH, 20, framebuffer address width; must satisfy 2^ADDR_WIDTH >= H_VISIBLE*V_VISIBLE
BAR_SHIFT, 4, log2 of bar/checker cell size in pixels
FRAME_CNT_BITS, 16, frame counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin generation; sampled only in IDLE
continuous  in  1  latched at start; 1 = repeat frames until stop
stop  in  1  in continuous mode, end after the current frame completes
mode  in  3  pattern select; latched at start and at each frame boundary
fg_color  in  PIXEL_BITS  foreground color; latched with mode
bg_color  in  PIXEL_BITS  background color; latched with mode
busy  out  1  high in RUN
done  out  1  one-cycle pulse after final beat of the last frame
frame_count  out  FRAME_CNT_BITS  completed frames since reset; wraps
pix_valid  out  1  beat valid
pix_ready  in  1  downstream accepts
pix_addr  out  ADDR_WIDTH  y*H_VISIBLE + x
pix_color  out  PIXEL_BITS  {red, grn, blu}, red in MSBs

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on reset_n. While reset_n=0, all state clears immediately: state=IDLE; pix_valid, busy, done, pix_addr, pix_color, frame_count, x, y, and latched config all 0.
- States: IDLE, RUN.
- IDLE -> RUN when start=1. Latch mode, fg_color, bg_color, and continuous. Clear x, y, and stop_pending.
- Latency: pix_valid=1 with pix_addr=0 on the cycle after start.
- RUN handshake:
  - pix_addr and pix_color are registered.
  - They hold stable while pix_valid && !pix_ready.
  - They advance one pixel per accepted beat.
  - There are no bubbles while pix_ready=1.
- Address: kept as an incrementing counter, no multiplier. x wraps H_VISIBLE-1 -> 0 and increments y.
- Pattern evaluation uses the coordinate of the pixel being emitted.
  - mode 0, solid: fg_color.
  - mode 1, hbars: (y>>BAR_SHIFT)[0] ? fg_color : bg_color.
  - mode 2, vbars: (x>>BAR_SHIFT)[0] ? fg_color : bg_color.
  - mode 3, checker: ((x>>BAR_SHIFT) ^ (y>>BAR_SHIFT))[0] ? fg_color : bg_color.
  - mode 4, gradient: red=x[COLOR_BITS-1:0], grn=y[COLOR_BITS-1:0], blu=(x^y)[COLOR_BITS-1:0]; truncation wraps.
  - modes 5-7: bg_color.
- Last beat of a frame (x=H_VISIBLE-1, y=V_VISIBLE-1) accepted:
  - frame_count increments.
  - If continuous=1 and no stop is pending: the next cycle emits addr 0 of the next frame with no bubble. mode and colors are relatched on that boundary.
  - Otherwise: go to IDLE, pix_valid=0, busy=0, and done=1 for one cycle.
- stop=1 at any RUN cycle sets stop_pending. The current frame always completes; it is never truncated.
- start while in RUN is ignored.
- start on the same cycle as done is honoured (IDLE sees it the next cycle).
- frame_count wraps from all-ones to 0.
- reset_n asserted mid-frame aborts immediately with no done pulse. The next start begins at addr 0.

Optional Feature:
- Macro: GFX_PATTERN_ANIMATE_EN.
- When defined:
  - A COLOR_BITS-wide-or-wider offset register (width = x width) increments by 1 modulo H_VISIBLE at each completed frame, including the last one.
  - Pattern evaluation uses xe = (x + offset) mod H_VISIBLE in place of x. pix_addr is unaffected.
  - The offset clears on reset only.
- When undefined: offset logic is absent, and xe = x.

Test Plan:
- All scenarios use H_VISIBLE=8, V_VISIBLE=4, PIXEL_BITS=12, BAR_SHIFT=1, ADDR_WIDTH=5.
- Solid: mode 0, fg=12'hF00, ready=1, single start -> 32 consecutive beats, addr 0..31, all 12'hF00; done pulse on the cycle after addr 31 is accepted; frame_count=1; busy low afterwards.
- Checker with backpressure: mode 3, fg=12'hFFF, bg=12'h000, ready toggling pseudo-randomly -> each addr 0..31 accepted exactly once in order; addr 2 (x=2,y=0) = 12'hFFF; addr 10 (x=2,y=1) = 12'hFFF; addr 0 = 12'h000; outputs stable during stalls.
- Gradient: mode 4 -> addr 13 (x=5,y=1) = 12'h514; addr 31 (x=7,y=3) = 12'h734.
- Continuous: continuous=1, ready=1, stop pulsed during the 3rd frame -> 96 beats with no gap at the 31->0 wraps; done once; frame_count=3; mode changed mid-frame applies only from the next frame.
- Reset mid-frame: reset_n low while pix_addr=10 -> pix_valid=0 and pix_addr=0 immediately (asynchronously), no done; next start emits addr 0 first.
- With GFX_PATTERN_ANIMATE_EN, mode 2, continuous: frame 1 addr 0 = bg, addr 2 = fg; frame 2 addr 1 = fg (xe=2); without the macro, frame 2 addr 1 = bg.
